// File: rtl/isp_pkg.sv
// isp_pkg: constants and helpers shared across the ISP pixel pipeline
package isp_pkg;

    localparam int PIX_WIDTH    = 10;
    localparam int PIX_PER_BEAT = 4;
    localparam int LINE_PIX     = 1920;
    localparam int FRAME_LINES  = 1080;
    localparam int CNT_W        = 12;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/raw10_line_checker.sv
// raw10_line_checker: pixel/line counters on the output handshake, line length error and frame line count
module raw10_line_checker #(
    parameter int LINE_PIX = 1920
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_hs,
    input  logic        pix_user,
    input  logic        pix_last,
    output logic        line_err,
    output logic [11:0] frame_lines
);
    import isp_pkg::*;

    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] line_cnt;
    logic [CNT_W-1:0] pix_next;
    logic [CNT_W-1:0] line_next;

    // Next counter values: a frame-start pixel restarts both counts from zero before incrementing
    always_comb begin
        pix_next  = sat_inc(pix_user ? '0 : pix_cnt);
        line_next = pix_last ? sat_inc(pix_user ? '0 : line_cnt) : '0;
    end

    // Counter registers, registered line-length pulse and frame line latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt     <= '0;
            line_cnt    <= '0;
            frame_lines <= '0;
            line_err    <= 1'b0;
        end else begin
            line_err <= pix_hs && pix_last && pix_next != CNT_W'(LINE_PIX);
            if (pix_hs) begin
                pix_cnt <= pix_last ? '0 : pix_next;
                if (pix_user || pix_last) line_cnt <= line_next;
                if (pix_user) frame_lines <= line_cnt;
            end
        end
    end

endmodule

// File: rtl/raw10_axis_unpack.sv
// raw10_axis_unpack: serialises packed 4-pixel RAW10 beats into one pixel per clock with overflow and line checks
module raw10_axis_unpack #(
    parameter int DATA_WIDTH = 40,
    parameter int PIX_WIDTH  = 10,
    parameter int LINE_PIX   = 1920
) (
    input  logic                  I_clk,
    input  logic                  I_rst_n,
    input  logic [DATA_WIDTH-1:0] I_raw_tdata,
    input  logic                  I_raw_tvalid,
    input  logic                  I_raw_tuser,
    input  logic                  I_raw_tlast,
    output logic                  I_raw_tready,
    output logic [PIX_WIDTH-1:0]  O_pix_tdata,
    output logic                  O_pix_tvalid,
    output logic                  O_pix_tuser,
    output logic                  O_pix_tlast,
    input  logic                  O_pix_tready,
    input  logic                  I_err_clr,
    output logic                  O_overflow,
    output logic                  O_line_err,
    output logic [11:0]           O_frame_lines
);
    import isp_pkg::*;

    localparam logic [1:0] LAST_IDX = 2'(PIX_PER_BEAT - 1);

    logic [DATA_WIDTH-1:0] hold;
    logic                  hold_user;
    logic                  hold_last;
    logic                  full;
    logic [1:0]            idx;
    logic                  pix_hs;
    logic                  beat_done;
    logic                  accept;

    // Handshakes and pixel outputs; a new beat may load on the edge that retires the last pixel
    always_comb begin
        pix_hs       = full && O_pix_tready;
        beat_done    = pix_hs && idx == LAST_IDX;
        I_raw_tready = !full || beat_done;
        accept       = I_raw_tvalid && I_raw_tready;
        O_pix_tvalid = full;
        O_pix_tdata  = hold[32'(idx) * PIX_WIDTH +: PIX_WIDTH];
        O_pix_tuser  = hold_user && idx == 2'd0;
        O_pix_tlast  = hold_last && idx == LAST_IDX;
    end

    // Holding register: load on acceptance, step through pixels on each output handshake
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            hold      <= '0;
            hold_user <= 1'b0;
            hold_last <= 1'b0;
            full      <= 1'b0;
            idx       <= '0;
        end else if (accept) begin
            hold      <= I_raw_tdata;
            hold_user <= I_raw_tuser;
            hold_last <= I_raw_tlast;
            full      <= 1'b1;
            idx       <= '0;
        end else if (pix_hs) begin
            idx  <= idx + 2'd1;
            full <= !beat_done;
        end
    end

    // Sticky overflow for beats the producer pushed while not ready; setting beats clearing
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) O_overflow <= 1'b0;
        else if (I_raw_tvalid && !I_raw_tready) O_overflow <= 1'b1;
        else if (I_err_clr) O_overflow <= 1'b0;
    end

    raw10_line_checker #(
        .LINE_PIX(LINE_PIX)
    ) u_line_checker (
        .clk        (I_clk),
        .rst_n      (I_rst_n),
        .pix_hs     (pix_hs),
        .pix_user   (O_pix_tuser),
        .pix_last   (O_pix_tlast),
        .line_err   (O_line_err),
        .frame_lines(O_frame_lines)
    );

endmodule

// File: doc/raw10_axis_unpack.md
# raw10_axis_unpack

Serialises the packed 4-pixel RAW10 AXI-stream beats produced by the image-correction stage into one 10-bit pixel per clock, preserving frame-start (tuser) and end-of-line (tlast) markers. It also checks line length, counts lines per frame, and flags beats dropped because the producer ignored backpressure. It sits directly downstream of image correction and feeds the per-pixel ISP pipeline (demosaic and friends).

## Interface
Parameters:
- DATA_WIDTH, 40, input beat width; always 4 × PIX_WIDTH
- PIX_WIDTH, 10, bits per pixel
- LINE_PIX, 1920, expected pixels per line

Ports:
- I_clk  in  1  pixel clock; the single clock
- I_rst_n  in  1  reset; asynchronous, active-low
- I_raw_tdata  in  DATA_WIDTH  packed beat; pixel 0 in [9:0], pixel 3 in [39:30]
- I_raw_tvalid  in  1  beat valid
- I_raw_tuser  in  1  first beat of frame
- I_raw_tlast  in  1  last beat of line
- I_raw_tready  out  1  beat accepted when high with tvalid
- O_pix_tdata  out  PIX_WIDTH  pixel
- O_pix_tvalid  out  1  pixel valid
- O_pix_tuser  out  1  first pixel of frame
- O_pix_tlast  out  1  last pixel of line
- O_pix_tready  in  1  downstream ready
- I_err_clr  in  1  one-cycle pulse; clears sticky flags
- O_overflow  out  1  sticky: beat offered while I_raw_tready low
- O_line_err  out  1  one-cycle pulse: line length ≠ LINE_PIX
- O_frame_lines  out  12  lines in previous frame, latched on tuser

## Operation
- Holding register: data, user, last, `full` flag, 2-bit pixel index `idx`.
- I_raw_tready = !full || (O_pix_tvalid && O_pix_tready && idx==3). This is combinational, with no bubble between beats.
- On acceptance: load the beat, idx←0, full←1.
- Output is driven combinationally from the registers:
  - O_pix_tdata = hold[idx*10 +: 10]
  - O_pix_tvalid = full
  - O_pix_tuser = hold_user && idx==0
  - O_pix_tlast = hold_last && idx==3
- On a pixel handshake: idx←idx+1. At idx==3, either full←0 or a new beat loads in the same edge.
- O_pix_tdata/tuser/tlast hold stable while tvalid && !tready.
- Pixel counter (12 bits, saturating at 4095):
  - Increments per output handshake.
  - On a handshake with tlast: if count+1 ≠ LINE_PIX, pulse O_line_err next cycle; reset to 0.
  - A tuser pixel resets it to 1.
- Line counter (12 bits, saturating):
  - Increments on each tlast handshake.
  - On a tuser handshake: O_frame_lines←line counter, line counter←0.
  - The first frame after reset latches 0.
- Overflow: I_raw_tvalid && !I_raw_tready sets O_overflow. The beat is dropped and the holding register is unaffected.
  - Cleared only by I_err_clr or reset.
  - Set wins over a simultaneous clear.

## Timing
- Reset values: all outputs 0, full=0, idx=0, counters 0. I_raw_tready reads 1 immediately after reset.
- Latency: a beat accepted at edge k presents pixel 0 at cycle k+1. Pixels 1–3 follow on successive handshakes.
- Throughput: one beat per 4 cycles at most; 4 pixels/beat sustained with O_pix_tready held high.
- O_line_err: registered, one cycle after the offending tlast handshake.
- O_frame_lines: updates one cycle after the tuser handshake.
- Reset mid-line: the partial beat is discarded and counters are zeroed. Output resumes cleanly at the next accepted beat.

## Structure
- Shared package `isp_pkg`: PIX_WIDTH, PIX_PER_BEAT=4, LINE_PIX, FRAME_LINES=1080, counter width 12.
- One natural sub-module, `raw10_line_checker`: pixel and line counters, O_line_err, O_frame_lines. It monitors only the output handshake.
- The top holds the serialiser and overflow logic.

## Test plan
- Reset, then one beat 0xFFC0300801 with tuser=1, tready held high → pixels 0x001, 0x002, 0x003, 0x3FF on consecutive cycles; tuser on 0x001 only; I_raw_tready low for 3 cycles.
- 480 beats with tlast on the 480th, no stalls → 1920 pixels, tlast on pixel 1920, no O_line_err.
- Line of 479 beats with tlast → O_line_err pulses once, one cycle after pixel 1916.
- O_pix_tready toggled randomly (~50%) over 2 lines → pixel sequence identical to the no-stall case; data stable during stalls.
- Beat offered while I_raw_tready=0 → O_overflow=1 next cycle and stays set; held beat output unchanged; I_err_clr → 0.
- 1080 lines, then tuser → O_frame_lines=1080. Assert I_rst_n low mid-line → all outputs 0; the next frame unpacks correctly.
